// File: rtl/pipe_elastic_stage.sv
// ---------------------------------------------------------------------------
// pipe_elastic_stage
//   Elastic inter-stage register carrying one packed DATA_W-bit stage bundle
//   with a valid/ready handshake. With SKID=1 a 2-entry skid buffer makes
//   in_ready a pure state decode, so back-pressure never forms a
//   combinational path across the stage. With SKID=0 it is a single register
//   whose in_ready follows out_ready combinationally. A synchronous flush
//   squashes all held entries to an all-zero bubble.
//
// Parameters:
//   DATA_W  width of the stage bundle
//   SKID    1: 2-entry skid buffer, registered in_ready; 0: single register
//
// Ports:
//   clk        stage clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   upstream bundle valid
//   in_ready   stage can accept this cycle
//   in_data    upstream bundle
//   out_valid  head entry valid
//   out_ready  downstream accepts head this cycle
//   out_data   head entry bundle
//   flush      synchronous squash of all held entries
//   count      occupancy 0..2 (0..1 when SKID=0)
//   stall_cnt  (only with PIPE_ELASTIC_STAGE_PERF_EN defined) saturating
//              count of cycles with out_valid=1 and out_ready=0
//
// Optional feature macro: PIPE_ELASTIC_STAGE_PERF_EN
// ---------------------------------------------------------------------------
module pipe_elastic_stage #(
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        count
`ifdef PIPE_ELASTIC_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept, emit;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // State and data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Next state and data. main always holds the head, skid the younger
    // entry, so draining FULL moves skid into main to keep FIFO order.
    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash wins over everything; an accept in this cycle is dropped.
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Only reachable with a skid buffer: with SKID=0
                        // in_ready needs out_ready while ONE.
                        if (SKID != 0) begin
                            state_d = FULL;
                            skid_d  = in_data;
                        end
                    end else if (emit) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    if (SKID == 0) begin
                        state_d = EMPTY;
                        main_d  = '0;
                        skid_d  = '0;
                    end else if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        out_valid = (state != EMPTY);
        out_data  = main_q;
        case (state)
            ONE:     count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
        if (SKID != 0)
            in_ready = (state != FULL);
        else
            in_ready = !out_valid || out_ready;
    end

`ifdef PIPE_ELASTIC_STAGE_PERF_EN
    // Stall counter: survives flush, cleared by reset only, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_elastic_stage.sv
module tb_pipe_elastic_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic         in_valid, in_ready, out_valid, out_ready, flush;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   count;
    // SKID=0 instance
    logic         z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_flush;
    logic [W-1:0] z_in_data, z_out_data;
    logic [1:0]   z_count;
`ifdef PIPE_ELASTIC_STAGE_PERF_EN
    logic [31:0]  stall_cnt, z_stall_cnt;
`endif

    pipe_elastic_stage #(.DATA_W(W), .SKID(1)) u1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .count(count)
`ifdef PIPE_ELASTIC_STAGE_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipe_elastic_stage #(.DATA_W(W), .SKID(0)) u0 (
        .clk(clk), .reset(reset),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .flush(z_flush), .count(z_count)
`ifdef PIPE_ELASTIC_STAGE_PERF_EN
        , .stall_cnt(z_stall_cnt)
`endif
    );

    typedef struct {
        logic         vin;
        logic [W-1:0] din;
        logic         ordy;
        logic         fl;
        logic         ov;
        logic [W-1:0] od;
        logic [1:0]   cnt;
        logic         ir;
    } vec_t;

    vec_t         vq[$];
    logic [W-1:0] sbq[$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic vin, input logic [W-1:0] din, input logic ordy, input logic fl,
                       input logic ov, input logic [W-1:0] od, input logic [1:0] cnt, input logic ir);
        vec_t v;
        v.vin = vin; v.din = din; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir;
        vq.push_back(v);
    endtask

    // Scoreboard: emits pop and compare, accepts push, flush drops the rest.
    task automatic sb_sample();
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow at %0t: got emit of %0h expected none", $time, out_data);
            end else begin
                chk("sb_data", out_data, sbq.pop_front());
            end
        end
        if (flush)
            sbq.delete();
        else if (in_valid && in_ready)
            sbq.push_back(in_data);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = '0; out_ready = 1; flush = 0;
        z_in_valid = 0; z_in_data = '0; z_out_ready = 1; z_flush = 0;

        // Reset state while reset is held, before any edge
        #2;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", out_data, 0);
        chk("rst_cnt", 32'(count), 0);
        chk("rst_ir", 32'(in_ready), 1);
        chk("rst_z_ir", 32'(z_in_ready), 1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        //   vin din       ordy fl | ov od        cnt ir
        add(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        // streaming
        add(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add(1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1);
        add(1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1);
        add(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1);
        // back-pressure into skid, blocked offer while FULL, drain
        add(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1);
        add(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0);
        add(1'b1, 32'hA9, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0);
        add(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0);
        add(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1, 1'b1);
        add(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        // flush while FULL with a bundle offered
        add(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add(1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd1, 1'b1);
        add(1'b1, 32'hB3, 1'b0, 1'b1, 1'b1, 32'hB1, 2'd2, 1'b0);
        add(1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        // flush in ONE with concurrent emit and accept
        add(1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add(1'b1, 32'hC2, 1'b1, 1'b1, 1'b1, 32'hC1, 2'd1, 1'b1);
        add(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        // flush while EMPTY with an accept
        add(1'b1, 32'hD1, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1);
        add(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);

        foreach (vq[i]) begin
            in_valid = vq[i].vin; in_data = vq[i].din;
            out_ready = vq[i].ordy; flush = vq[i].fl;
            @(negedge clk);
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vq[i].ov));
            chk($sformatf("v%0d_od", i), out_data, vq[i].od);
            chk($sformatf("v%0d_cnt", i), 32'(count), 32'(vq[i].cnt));
            chk($sformatf("v%0d_ir", i), 32'(in_ready), 32'(vq[i].ir));
            sb_sample();
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 0;
        chk("sb_empty", 32'(sbq.size()), 0);

        // Asynchronous reset with two entries held
        in_valid = 1; in_data = 32'hF1; out_ready = 0;
        @(posedge clk); #1;
        in_data = 32'hF2;
        @(posedge clk); #1;
        in_valid = 0;
        chk("mr_full_cnt", 32'(count), 2);
        #2 reset = 1'b1;
        #1;
        chk("mr_ov", 32'(out_valid), 0);
        chk("mr_od", out_data, 0);
        chk("mr_cnt", 32'(count), 0);
        chk("mr_ir", 32'(in_ready), 1);
`ifdef PIPE_ELASTIC_STAGE_PERF_EN
        chk("mr_stall", stall_cnt, 0);
`endif
        sbq.delete();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

`ifdef PIPE_ELASTIC_STAGE_PERF_EN
        // Five stalled edges, then a stalled flush cycle
        in_valid = 1; in_data = 32'hE1; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("perf_5", stall_cnt, 5);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("perf_flush_ov", 32'(out_valid), 0);
        chk("perf_6", stall_cnt, 6);
        @(posedge clk); #1;
        chk("perf_hold", stall_cnt, 6);
        out_ready = 1;
`endif

        // SKID=0: combinational ready follows out_ready
        z_in_valid = 1; z_in_data = 32'hC1; z_out_ready = 0;
        #3;
        chk("z_empty_ir", 32'(z_in_ready), 1);
        @(posedge clk); #1;
        z_in_data = 32'hC9;
        #1;
        chk("z_ov", 32'(z_out_valid), 1);
        chk("z_od_c1", z_out_data, 32'hC1);
        chk("z_ir_low", 32'(z_in_ready), 0);
        chk("z_cnt1", 32'(z_count), 1);
        z_out_ready = 1; z_in_data = 32'hC2;
        #1;
        chk("z_ir_high", 32'(z_in_ready), 1);
        @(posedge clk); #1;
        z_in_valid = 0;
        chk("z_od_c2", z_out_data, 32'hC2);
        chk("z_cnt_pass", 32'(z_count), 1);
        @(posedge clk); #1;
        chk("z_ov_done", 32'(z_out_valid), 0);
        chk("z_cnt0", 32'(z_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_elastic_stage.md
Name: pipe_elastic_stage

Overview:
- Parametrised, elastic successor to the fixed-field inter-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries one packed DATA_W-bit stage bundle with a valid/ready handshake instead of a bare write enable.
- An optional 2-entry skid buffer lets back-pressure from a downstream stage register, so no combinational ready path crosses the stage.
- Synchronous flush inserts an all-zero bubble (NOP) for branch and jump squash.

Parameters:
- DATA_W, 32: width of the packed stage bundle.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head this cycle.
- out_data  out  DATA_W  head entry bundle.
- flush  in  1  synchronous squash of all held entries.
- count  out  2  occupancy, 0 to 2 (0 to 1 when SKID=0).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state EMPTY, main and skid registers all zero, out_valid=0, out_data=0, count=0. in_ready=1 while reset is held and after it is released.
- Handshake events:
  - accept = in_valid & in_ready.
  - emit = out_valid & out_ready.
  - in_data is sampled only on accept.
  - out_data/out_valid are held stable while out_valid=1 and out_ready=0.
- Outputs are decoded from state: out_valid = (state != EMPTY); out_data = main; count = 0/1/2 for EMPTY/ONE/FULL.
- Ready, SKID=1: in_ready = (state != FULL), decoded from state only, with no path from out_ready.
- Ready, SKID=0: in_ready = !out_valid | out_ready (combinational); FULL is unreachable.
- State transitions, evaluated when flush=0:
  - EMPTY, accept: go to ONE, main <= in_data.
  - ONE, accept & emit: stay ONE, main <= in_data (1 bundle per cycle throughput).
  - ONE, accept & !emit: go to FULL, skid <= in_data (SKID=1 only).
  - ONE, !accept & emit: go to EMPTY, main <= 0.
  - ONE, !accept & !emit: hold.
  - FULL, emit: go to ONE, main <= skid, skid <= 0. in_ready is 0 in FULL, so no simultaneous accept is possible.
  - FULL, !emit: hold.
- Latency: the bundle accepted at edge N is visible on out_data after edge N, i.e. 1 cycle when EMPTY or when ONE with a concurrent emit.
- Ordering: strict FIFO. The skid entry never overtakes main.
- Flush (highest priority, synchronous):
  - At the edge: state goes to EMPTY, main and skid go to 0.
  - Any bundle presented in the flush cycle is discarded even if accept=1.
  - Upstream sees the handshake as completed; the data is dropped.
  - An emit in the same cycle still completes downstream.
  - out_valid=0 and out_data=0 from the next cycle.
- Reset mid-operation: immediate return to the reset values, regardless of clk. In-flight bundles are lost.
- Illegal state encodings (when SKID=0) return to EMPTY on the next edge.

Optional Feature:
- Macro: PIPE_ELASTIC_STAGE_PERF_EN.
- With the macro defined:
  - Adds output port stall_cnt (out, 32): counts cycles with out_valid=1 & out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared to 0 by reset only; flush does not clear it.
  - Increments in the flush cycle if the condition holds.
- Without the macro: no stall_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: assert reset mid-cycle with 2 entries held -> out_valid=0, out_data=0, count=0, in_ready=1 immediately, before any clk edge.
- Streaming, SKID=1, out_ready=1: send 0x11, 0x22, 0x33 on consecutive cycles -> each appears 1 cycle later in order, count stays 1, in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0, send 0xA1 then 0xA2.
  - After 2 edges: count=2, in_ready=0, out_data=0xA1 held.
  - Raise out_ready: 0xA1 then 0xA2 emitted on successive cycles, count goes 1 then 0.
- Flush:
  - Stimulus: hold 0xB1 and 0xB2 (FULL), pulse flush with in_valid=1, in_data=0xB3.
  - Next cycle: out_valid=0, out_data=0, count=0.
  - 0xB3 never appears at the output.
- SKID=0 instance: out_ready=0 with 0xC1 held -> in_ready=0 in the same cycle. Raising out_ready combinationally raises in_ready; 0xC2 is accepted while 0xC1 is emitted.
- PERF_EN: hold out_valid=1 with out_ready=0 for 5 cycles, then flush -> stall_cnt=5 (or 6 if the flush cycle also stalled), and it remains non-zero after the flush.
